mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  RV32I pipeline MEM stage. Consumes the EX/MEM bundle and drives the data-memory port.
//  Aligns load data and store data, and produces the MEM/WB register.
//  The MEM/WB register's rd_s/regf_we feed operand forwarding in EX.
//  Stalls all upstream stages while a dmem access is outstanding.
// PARAMETERS
//  none: RV32I only, all widths fixed.
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  ex_valid     in   1   EX/MEM holds a valid instruction
//  ex_opcode    in   7   instruction opcode
//  ex_funct3    in   3   instruction funct3
//  ex_rd_s      in   5   destination register index
//  ex_regf_we   in   1   instruction writes the regfile
//  ex_alu_out   in   32  effective address (ld/st); otherwise ignored
//  ex_rd_v      in   32  writeback value for non-load instructions
//  ex_rs2_v     in   32  store data
//  dmem_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  dmem_rmask   out  4   byte read enables; nonzero = read request
//  dmem_wmask   out  4   byte write enables; nonzero = write request
//  dmem_wdata   out  32  lane-shifted store data
//  dmem_rdata   in   32  read data, valid when dmem_resp=1
//  dmem_resp    in   1   one-cycle completion pulse for the current request
//  mem_stall    out  1   upstream stages hold their state this cycle
//  wb_valid     out  1   MEM/WB register holds a valid instruction
//  wb_rd_s      out  5   MEM/WB destination register
//  wb_regf_we   out  1   MEM/WB regfile write enable
//  wb_rd_v      out  32  MEM/WB writeback value
//  mem_err      out  1   MEM/WB instruction was misaligned or had an illegal funct3
// BEHAVIOUR
//  Opcodes: load = 7'b0000011, store = 7'b0100011; all other opcodes are non-memory.
//  Reset (rst=0): state=IDLE; all outputs 0 immediately and held 0 while rst=0.
//  FSM state IDLE, ex_valid=0: next edge writes wb_valid=0 and wb_regf_we=0.
//  FSM state IDLE, non-memory op: mem_stall=0; next edge writes wb_* = ex_*, wb_rd_v = ex_rd_v.
//   Latency is 1 cycle.
//  FSM state IDLE, legal and aligned ld/st: mem_stall=1 combinationally.
//   Next edge registers addr, masks and wdata, then moves to WAIT.
//   That edge writes wb_valid=0 (bubble).
//  FSM state WAIT: dmem_* outputs come only from registers and stay stable until dmem_resp.
//   ex_* inputs are ignored.
//   mem_stall = !dmem_resp.
//  FSM state WAIT, dmem_resp=1: next edge loads the MEM/WB register and clears masks to 0.
//   Same edge returns state to IDLE; upstream advances on that same edge.
//   For a load, wb_rd_v = extended read data. Earliest response is the first WAIT cycle,
//   giving a minimum load/store latency of 2 cycles.
//  dmem_resp in IDLE is ignored, including a response left over from a request cut off by reset.
//  Address alignment: a = ex_alu_out[1:0].
//  Store widths: sb: wmask=4'b0001<<a, wdata=rs2<<(8*a);
//   sh: wmask=4'b0011<<a, wdata=rs2<<(8*a); sw: wmask=4'b1111.
//  Load masks: lb/lbu rmask=4'b0001<<a; lh/lhu rmask=4'b0011<<a; lw rmask=4'b1111.
//  Load data: the selected byte/half of dmem_rdata is sign-extended (lb, lh)
//   or zero-extended (lbu, lhu).
//  Misaligned: lh/lhu/sh with a[0]=1, or lw/sw with a!=0.
//  Illegal funct3: load 011/110/111, store 011-111.
//  Misaligned or illegal-funct3 access: no dmem request, mem_stall=0.
//   Next edge writes wb_valid=1, wb_regf_we=0, mem_err=1.
//  Stores always write wb_regf_we=0. mem_err is 0 for every other instruction.
//  Reset asserted in WAIT: the request is dropped at once (masks=0) and state=IDLE.
// TESTING
//  lw, ex_alu_out=0x100, dmem_resp in 3rd WAIT cycle with rdata=0xDEADBEEF ->
//   addr=0x100 and rmask=1111 held 3 cycles; mem_stall=1 for 3 cycles;
//   wb_rd_v=0xDEADBEEF and wb_regf_we=1 one cycle after resp.
//  lb at 0x103, rdata=0x80123456 -> rmask=1000, wb_rd_v=0xFFFFFF80;
//   lbu at the same address -> wb_rd_v=0x00000080.
//  sh at 0x202, rs2=0x0000ABCD -> addr=0x200, wmask=1100, wdata=0xABCD0000;
//   wb_regf_we=0 after resp.
//  lw at 0x101 -> masks stay 0, mem_stall=0; next cycle wb_valid=1, wb_regf_we=0, mem_err=1.
//  ALU op (rd=5, ex_rd_v=0x1234), then lw, then ALU op back-to-back ->
//   wb rd=5 value 0x1234 after 1 cycle, then the load, then the 2nd ALU op; no instruction lost.
//  rst low during WAIT, dmem_resp pulse after release -> outputs 0 during reset;
//   stray resp ignored; next lw issues normally.

Source files
------------

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues data-memory requests from the EX/MEM bundle,
// aligns load/store data and produces the MEM/WB register.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd_s,
    input  logic        ex_regf_we,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rd_v,
    input  logic [31:0] ex_rs2_v,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_s,
    output logic        wb_regf_we,
    output logic [31:0] wb_rd_v,
    output logic        mem_err
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned MASKW = 4;
    localparam int unsigned REGW  = 5;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [MASKW-1:0] rmask_q, rmask_d;
    logic [MASKW-1:0] wmask_q, wmask_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       lane_q, lane_d;
    logic             is_load_q, is_load_d;
    logic [REGW-1:0]  rd_s_q, rd_s_d;
    logic             regf_we_q, regf_we_d;

    logic             wb_valid_d;
    logic [REGW-1:0]  wb_rd_s_d;
    logic             wb_regf_we_d;
    logic [XLEN-1:0]  wb_rd_v_d;
    logic             mem_err_d;
    logic             stall_raw;

    logic [1:0]       ex_lane;
    logic             is_load, is_store, f3_legal, misaligned, mem_ok, mem_bad;
    logic [MASKW-1:0] size_mask, lane_mask;
    logic [XLEN-1:0]  rdata_sh, load_val;

    // Decode the EX/MEM access: legality, alignment and byte-lane mask
    always_comb begin
        ex_lane  = ex_alu_out[1:0];
        is_load  = (ex_opcode == OP_LOAD);
        is_store = (ex_opcode == OP_STORE);
        f3_legal = 1'b0;
        if (is_load) begin
            f3_legal = (ex_funct3 != 3'b011) && (ex_funct3[2:1] != 2'b11);
        end
        if (is_store) begin
            f3_legal = !ex_funct3[2] && (ex_funct3[1:0] != 2'b11);
        end
        misaligned = ((ex_funct3[1:0] == 2'b01) && ex_lane[0])
                  || ((ex_funct3[1:0] == 2'b10) && (ex_lane != 2'b00));
        mem_ok  = ex_valid && (is_load || is_store) && f3_legal && !misaligned;
        mem_bad = ex_valid && (is_load || is_store) && !(f3_legal && !misaligned);
        case (ex_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        lane_mask = size_mask << ex_lane;
    end

    // Select and extend the addressed byte/half of the returned word
    always_comb begin
        rdata_sh = dmem_rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_val = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_val = {24'b0, rdata_sh[7:0]};
            3'b101:  load_val = {16'b0, rdata_sh[15:0]};
            default: load_val = rdata_sh;
        endcase
    end

    // Next-state, request registers and MEM/WB register inputs
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rmask_d      = rmask_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        is_load_d    = is_load_q;
        rd_s_d       = rd_s_q;
        regf_we_d    = regf_we_q;
        wb_valid_d   = wb_valid;
        wb_rd_s_d    = wb_rd_s;
        wb_regf_we_d = wb_regf_we;
        wb_rd_v_d    = wb_rd_v;
        mem_err_d    = mem_err;
        stall_raw    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_raw    = mem_ok;
                wb_valid_d   = ex_valid;
                wb_rd_s_d    = ex_rd_s;
                wb_regf_we_d = ex_valid && ex_regf_we;
                wb_rd_v_d    = ex_rd_v;
                mem_err_d    = 1'b0;
                if (mem_ok) begin
                    state_d      = S_WAIT;
                    addr_d       = {ex_alu_out[31:2], 2'b00};
                    rmask_d      = is_load  ? lane_mask : 4'b0000;
                    wmask_d      = is_store ? lane_mask : 4'b0000;
                    wdata_d      = is_store ? (ex_rs2_v << {ex_lane, 3'b000}) : '0;
                    funct3_d     = ex_funct3;
                    lane_d       = ex_lane;
                    is_load_d    = is_load;
                    rd_s_d       = ex_rd_s;
                    regf_we_d    = is_load && ex_regf_we;
                    wb_valid_d   = 1'b0;
                    wb_regf_we_d = 1'b0;
                end else if (mem_bad) begin
                    wb_regf_we_d = 1'b0;
                    wb_rd_v_d    = '0;
                    mem_err_d    = 1'b1;
                end
            end
            default: begin
                stall_raw = !dmem_resp;
                if (dmem_resp) begin
                    state_d      = S_IDLE;
                    rmask_d      = 4'b0000;
                    wmask_d      = 4'b0000;
                    wb_valid_d   = 1'b1;
                    wb_rd_s_d    = rd_s_q;
                    wb_regf_we_d = regf_we_q;
                    wb_rd_v_d    = is_load_q ? load_val : '0;
                    mem_err_d    = 1'b0;
                end
            end
        endcase
    end

    // Stall is forced low while reset is held
    assign mem_stall = rst && stall_raw;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and MEM/WB registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            rmask_q    <= '0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            lane_q     <= '0;
            is_load_q  <= 1'b0;
            rd_s_q     <= '0;
            regf_we_q  <= 1'b0;
            wb_valid   <= 1'b0;
            wb_rd_s    <= '0;
            wb_regf_we <= 1'b0;
            wb_rd_v    <= '0;
            mem_err    <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            rmask_q    <= rmask_d;
            wmask_q    <= wmask_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            is_load_q  <= is_load_d;
            rd_s_q     <= rd_s_d;
            regf_we_q  <= regf_we_d;
            wb_valid   <= wb_valid_d;
            wb_rd_s    <= wb_rd_s_d;
            wb_regf_we <= wb_regf_we_d;
            wb_rd_v    <= wb_rd_v_d;
            mem_err    <= mem_err_d;
        end
    end

    assign dmem_addr  = addr_q;
    assign dmem_rmask = rmask_q;
    assign dmem_wmask = wmask_q;
    assign dmem_wdata = wdata_q;

endmodule
